// File: rtl/btn_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_pkg
// Description : Shared types and defaults for the button gesture decoder:
//               FSM state encoding, default timing constants and a helper
//               that tells which states run the gesture timer.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

  // Gesture FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } btn_state_t;

  // Default timing in 1 kHz clock cycles (milliseconds)
  localparam int BTN_LONG_MS_DEF   = 1000;
  localparam int BTN_DCLICK_MS_DEF = 300;

  // States in which the shared counter advances every cycle
  function automatic logic is_counting(input btn_state_t s);
    return (s == ST_PRESSED) || (s == ST_WAIT_SECOND) || (s == ST_SECOND_PRESSED);
  endfunction

endpackage : btn_evt_pkg
`default_nettype wire

// File: rtl/btn_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_decoder_if
// Description : Button level in, gesture strobes and busy flag out.
//               master = UI/control side, slave = decoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_decoder_if;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  double_click,
    input  busy
  );

  modport slave (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output double_click,
    output busy
  );

endinterface : btn_event_decoder_if
`default_nettype wire

// File: rtl/btn_event_decoder_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_det
// Description : Registers a debounced level and flags its rising and falling
//               edges combinationally against the registered copy. Usable by
//               any 1 kHz input stage.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_det (
  input  logic clk_1Khz,
  input  logic rst_n,
  input  logic btn_level,
  output logic btn_q,
  output logic rise,
  output logic fall
);

  logic r_btn_q;

  // Previous-cycle copy of the level; cleared so a held button after reset reads as a rise
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) r_btn_q <= 1'b0;
    else        r_btn_q <= btn_level;
  end

  assign btn_q = r_btn_q;
  assign rise  = btn_level & ~r_btn_q;
  assign fall  = ~btn_level & r_btn_q;

endmodule : btn_edge_det
`default_nettype wire

// File: rtl/btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_decoder
// Description : Turns the debounced button level into one-cycle gesture
//               strobes: press, release, short press, long press and
//               double click. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = BTN_LONG_MS_DEF,
  parameter int DCLICK_MS = BTN_DCLICK_MS_DEF,
  parameter int CNT_W     = 12
) (
  input  logic               clk_1Khz,
  input  logic               rst_n,
  btn_event_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_MS - 1);

  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_btn_q;
  logic w_rise;
  logic w_fall;
  logic w_long;
  logic w_short;
  logic w_dclick;

  logic r_press;
  logic r_release;
  logic r_short;
  logic r_long;
  logic r_dclick;
  logic r_busy;

  btn_edge_det u_edge (
    .clk_1Khz  (clk_1Khz),
    .rst_n     (rst_n),
    .btn_level (bus.btn_level),
    .btn_q     (w_btn_q),
    .rise      (w_rise),
    .fall      (w_fall)
  );

  // State register and gesture timer; timer restarts on every state change
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)  r_cnt <= '0;
      else if (is_counting(r_state)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next state; an edge always takes priority over a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (w_rise) w_state_nxt = ST_PRESSED;
      ST_PRESSED:
        if (w_fall)                                 w_state_nxt = ST_WAIT_SECOND;
        else if (w_btn_q && (r_cnt == c_long_last)) w_state_nxt = ST_LONG_HELD;
      ST_LONG_HELD:
        if (w_fall) w_state_nxt = ST_IDLE;
      ST_WAIT_SECOND:
        if (w_rise)                                    w_state_nxt = ST_SECOND_PRESSED;
        else if (!w_btn_q && (r_cnt == c_dclick_last)) w_state_nxt = ST_IDLE;
      ST_SECOND_PRESSED:
        if (w_fall)                                 w_state_nxt = ST_IDLE;
        else if (w_btn_q && (r_cnt == c_long_last)) w_state_nxt = ST_LONG_HELD;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  // Gesture decisions for this cycle, registered below into strobes
  always_comb begin
    w_long   = 1'b0;
    w_short  = 1'b0;
    w_dclick = 1'b0;
    if ((r_state == ST_PRESSED) || (r_state == ST_SECOND_PRESSED))
      w_long = !w_fall && w_btn_q && (r_cnt == c_long_last);
    if (r_state == ST_WAIT_SECOND)
      w_short = !w_rise && !w_btn_q && (r_cnt == c_dclick_last);
    if (r_state == ST_SECOND_PRESSED)
      w_dclick = w_fall;
  end

  // Output registers; busy tracks the state register cycle for cycle
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_dclick  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_short   <= w_short;
      r_long    <= w_long;
      r_dclick  <= w_dclick;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.short_press   = r_short;
  assign bus.long_press    = r_long;
  assign bus.double_click  = r_dclick;
  assign bus.busy          = r_busy;

endmodule : btn_event_decoder
`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_decoder
// Description : Directed gesture scenarios for btn_event_decoder with
//               LONG_MS = 20 and DCLICK_MS = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_decoder;

  logic clk_1Khz = 1'b0;
  logic rst_n;

  btn_event_decoder_if bus ();

  btn_event_decoder #(
    .LONG_MS   (20),
    .DCLICK_MS (8),
    .CNT_W     (12)
  ) dut (
    .clk_1Khz (clk_1Khz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_1Khz = ~clk_1Khz;

  int cyc = 0;
  always @(posedge clk_1Khz) cyc <= cyc + 1;

  // Event counters and cycle stamps of the most recent occurrence
  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dclick = 0;
  int t_press = -1, t_rel = -1, t_short = -1, t_long = -1, t_dclick = -1;

  always @(negedge clk_1Khz) begin
    if (bus.press_pulse)   begin n_press  = n_press  + 1; t_press  = cyc; end
    if (bus.release_pulse) begin n_rel    = n_rel    + 1; t_rel    = cyc; end
    if (bus.short_press)   begin n_short  = n_short  + 1; t_short  = cyc; end
    if (bus.long_press)    begin n_long   = n_long   + 1; t_long   = cyc; end
    if (bus.double_click)  begin n_dclick = n_dclick + 1; t_dclick = cyc; end
  end

  int b_press, b_rel, b_short, b_long, b_dclick;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    if (obs != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_press = n_press; b_rel = n_rel; b_short = n_short; b_long = n_long; b_dclick = n_dclick;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_1Khz);
  endtask

  // Press for 'hold' cycles then release
  task automatic tap(input int hold);
    bus.btn_level = 1'b1;
    cycles(hold);
    bus.btn_level = 1'b0;
  endtask

  function automatic int outs();
    return int'({bus.press_pulse, bus.release_pulse, bus.short_press,
                 bus.long_press, bus.double_click, bus.busy});
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.btn_level = 1'b0;
    cycles(3);
    #1;
    check_val("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    cycles(2);

    // Short press: held 5, released, idle
    snap();
    tap(5);
    cycles(15);
    #1;
    check_val("s1_press",    n_press - b_press, 1);
    check_val("s1_release",  n_rel - b_rel, 1);
    check_val("s1_short",    n_short - b_short, 1);
    check_val("s1_short_dt", t_short - t_rel, 8);
    check_val("s1_long",     n_long - b_long, 0);
    check_val("s1_dclick",   n_dclick - b_dclick, 0);
    check_val("s1_busy",     int'(bus.busy), 0);

    // Long press: held 30
    snap();
    tap(30);
    cycles(15);
    #1;
    check_val("s2_long",    n_long - b_long, 1);
    check_val("s2_long_dt", t_long - t_press, 20);
    check_val("s2_release", n_rel - b_rel, 1);
    check_val("s2_short",   n_short - b_short, 0);

    // Double click: press 4, gap 3, press 4
    snap();
    tap(4);
    cycles(3);
    tap(4);
    cycles(15);
    #1;
    check_val("s3_press",     n_press - b_press, 2);
    check_val("s3_dclick",    n_dclick - b_dclick, 1);
    check_val("s3_dclick_at", t_dclick, t_rel);
    check_val("s3_short",     n_short - b_short, 0);
    check_val("s3_long",      n_long - b_long, 0);

    // Release on the same cycle the long timeout would fire
    snap();
    tap(20);
    cycles(15);
    #1;
    check_val("b1_long",     n_long - b_long, 0);
    check_val("b1_short",    n_short - b_short, 1);
    check_val("b1_short_dt", t_short - t_rel, 8);

    // Second press on the same cycle the short timeout would fire
    snap();
    tap(4);
    cycles(8);
    tap(4);
    cycles(15);
    #1;
    check_val("b2_dclick", n_dclick - b_dclick, 1);
    check_val("b2_short",  n_short - b_short, 0);

    // Second press held long
    snap();
    tap(4);
    cycles(3);
    tap(25);
    cycles(15);
    #1;
    check_val("s5_long",    n_long - b_long, 1);
    check_val("s5_long_dt", t_long - t_press, 20);
    check_val("s5_dclick",  n_dclick - b_dclick, 0);
    check_val("s5_short",   n_short - b_short, 0);
    check_val("s5_release", n_rel - b_rel, 2);

    // Reset during PRESSED at cnt = 10, button kept held through reset
    bus.btn_level = 1'b1;
    cycles(11);
    #1;
    check_val("rm_busy_before", int'(bus.busy), 1);
    snap();
    rst_n = 1'b0;
    #1;
    check_val("rm_outputs", outs(), 0);
    cycles(2);
    check_val("rm_no_events", (n_press - b_press) + (n_rel - b_rel) + (n_short - b_short)
                              + (n_long - b_long) + (n_dclick - b_dclick), 0);
    rst_n = 1'b1;
    snap();
    cycles(1);
    #1;
    check_val("rm_press",    n_press - b_press, 1);
    check_val("rm_press_at", t_press, cyc);
    check_val("rm_busy",     int'(bus.busy), 1);
    bus.btn_level = 1'b0;
    cycles(15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_btn_event_decoder
`default_nettype wire
